// File: rtl/dec_sched.sv
// dec_sched: shares one 64-bit one-hot decoder between N_REQ requesters.
// A round-robin arbiter issues one index per cycle to the decoder. The
// requester id of each issue is queued in a tag FIFO so the in-order
// decoder results can be routed back to their owners. Credits are bounded
// by MAX_OUT outstanding operations.
module dec_sched #(
  parameter int N_REQ   = 4,
  parameter int MAX_OUT = 4,
  localparam int IDW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [N_REQ-1:0]   req_valid_i,
  input  logic [6*N_REQ-1:0] req_data_i,
  output logic [N_REQ-1:0]   req_ready_o,
  output logic [5:0]         dec_data_o,
  output logic               dec_valid_o,
  input  logic [63:0]        dec_data_i,
  input  logic               dec_valid_i,
  output logic               resp_valid_o,
  output logic [IDW-1:0]     resp_id_o,
  output logic [63:0]        resp_data_o,
  output logic               busy_o,
  output logic               err_o
);

  localparam int CW = $clog2(MAX_OUT + 1);
  localparam int PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

  logic [IDW-1:0] ptr_q, ptr_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [IDW-1:0] tag_mem_q [MAX_OUT];

  logic           dec_valid_q;
  logic [5:0]     dec_data_q, dec_data_d;
  logic           resp_valid_q;
  logic [IDW-1:0] resp_id_q, resp_id_d;
  logic [63:0]    resp_data_q, resp_data_d;
  logic           busy_q;
  logic           err_q;

  logic           found;
  logic [IDW-1:0] gnt_idx;
  logic [IDW:0]   cand;
  logic [5:0]     gnt_data;
  logic           can_issue;
  logic           xfer;
  logic           pop;
  logic           spurious;

  // Round-robin search: first valid requester at or above ptr, wrapping.
  // The candidate index carries one extra bit so the wrap compare cannot
  // overflow for any legal N_REQ.
  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = {1'b0, ptr_q} + (IDW+1)'(i);
      if (cand >= (IDW+1)'(N_REQ)) begin
        cand = cand - (IDW+1)'(N_REQ);
      end
      if (!found && req_valid_i[cand[IDW-1:0]]) begin
        found   = 1'b1;
        gnt_idx = cand[IDW-1:0];
      end
    end
  end

  // Select the granted requester's index field.
  always_comb begin
    gnt_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt_idx == IDW'(i)) begin
        gnt_data = req_data_i[6*i +: 6];
      end
    end
  end

  // A full credit count blocks every grant; a result returning in the same
  // cycle does not free a credit until the next cycle.
  assign can_issue   = !rst_i && found && (cnt_q < CW'(MAX_OUT));
  assign req_ready_o = can_issue ? (N_REQ'(1) << gnt_idx) : '0;
  assign xfer        = can_issue;
  assign pop         = dec_valid_i && (cnt_q != '0);
  assign spurious    = dec_valid_i && (cnt_q == '0);

  // Next-state for pointers, credit counter and output holding registers.
  always_comb begin
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    dec_data_d  = dec_data_q;
    resp_id_d   = resp_id_q;
    resp_data_d = resp_data_q;

    if (xfer) begin
      ptr_d      = (gnt_idx == IDW'(N_REQ - 1)) ? '0 : gnt_idx + IDW'(1);
      wr_ptr_d   = (wr_ptr_q == PW'(MAX_OUT - 1)) ? '0 : wr_ptr_q + PW'(1);
      dec_data_d = gnt_data;
    end

    if (pop) begin
      rd_ptr_d    = (rd_ptr_q == PW'(MAX_OUT - 1)) ? '0 : rd_ptr_q + PW'(1);
      resp_id_d   = tag_mem_q[rd_ptr_q];
      resp_data_d = dec_data_i;
    end

    case ({xfer, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q        <= '0;
      cnt_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      dec_valid_q  <= 1'b0;
      dec_data_q   <= '0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= '0;
      resp_data_q  <= '0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      ptr_q        <= ptr_d;
      cnt_q        <= cnt_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      dec_valid_q  <= xfer;
      dec_data_q   <= dec_data_d;
      resp_valid_q <= pop;
      resp_id_q    <= resp_id_d;
      resp_data_q  <= resp_data_d;
      busy_q       <= (cnt_d != '0);
      err_q        <= err_q | spurious;
    end
  end

  // Tag storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk_i) begin
    if (xfer) begin
      tag_mem_q[wr_ptr_q] <= gnt_idx;
    end
  end

  assign dec_valid_o  = dec_valid_q;
  assign dec_data_o   = dec_data_q;
  assign resp_valid_o = resp_valid_q;
  assign resp_id_o    = resp_id_q;
  assign resp_data_o  = resp_data_q;
  assign busy_o       = busy_q;
  assign err_o        = err_q;

  // Structural invariants of the arbiter and credit counter.
  a_ready_onehot: assert property (@(posedge clk_i) disable iff (rst_i)
    $onehot0(req_ready_o));
  a_cnt_bound: assert property (@(posedge clk_i) disable iff (rst_i)
    cnt_q <= CW'(MAX_OUT));
  a_ready_valid: assert property (@(posedge clk_i) disable iff (rst_i)
    (req_ready_o & ~req_valid_i) == '0);

endmodule

// File: doc/dec_sched.md
DEC_SCHED -- requirements
Module: dec_sched

Interface
REQ-001: Parameter N_REQ, default 4; number of requesters sharing one dec_64b decoder, range 2..16.
REQ-002: Parameter MAX_OUT, default 4; maximum outstanding decoder operations and depth of the internal tag FIFO, range 1..16.
REQ-003: Derived width IDW = max(1, clog2(N_REQ)); not user-settable.
REQ-004: clk_i  input  1  sole clock; all logic on the rising edge.
REQ-005: rst_i  input  1  synchronous reset, active-high.
REQ-006: req_valid_i  input  N_REQ  per-requester request valid.
REQ-007: req_data_i  input  6*N_REQ  per-requester 6-bit index; requester k occupies bits [6k+5:6k].
REQ-008: req_ready_o  output  N_REQ  per-requester accept, at most one bit set.
REQ-009: dec_data_o  output  6  index driven to the decoder in_data_i.
REQ-010: dec_valid_o  output  1  decoder in_valid_i.
REQ-011: dec_data_i  input  64  decoder out_data_o.
REQ-012: dec_valid_i  input  1  decoder out_valid_o.
REQ-013: resp_valid_o  output  1  routed result valid, one-cycle pulse per result.
REQ-014: resp_id_o  output  IDW  index of the requester that owns the result.
REQ-015: resp_data_o  output  64  decoded one-hot result.
REQ-016: busy_o  output  1  high while the outstanding count is non-zero.
REQ-017: err_o  output  1  sticky flag for a decoder result with no outstanding operation.

Function
REQ-018: Arbitration is round-robin with pointer ptr. The grant goes to the first k with req_valid_i[k]=1, searching from ptr upward modulo N_REQ.
REQ-019: req_ready_o is combinational: one-hot on the granted requester when cnt < MAX_OUT, else all zero.
REQ-020: A transfer occurs when req_valid_i[k] and req_ready_o[k] are both 1. On a transfer, ptr becomes (k+1) mod N_REQ; otherwise ptr holds.
REQ-021: Requesters hold req_data_i stable while valid and not ready. The block does not latch data before the transfer.
REQ-022: Issue latency is one cycle: the cycle after a transfer, dec_valid_o=1 and dec_data_o equals the transferred index. With no transfer, dec_valid_o=0 and dec_data_o holds its last value.
REQ-023: On each transfer, k is pushed into the tag FIFO (depth MAX_OUT). The FIFO cannot overflow because of REQ-019.
REQ-024: The outstanding counter cnt (width clog2(MAX_OUT+1)) updates each cycle:
- +1 on a transfer only;
- -1 on an accepted dec_valid_i only;
- unchanged when both occur in the same cycle.
REQ-025: cnt=MAX_OUT blocks all grants that cycle. There is no same-cycle bypass from a returning result.
REQ-026: dec_valid_i with cnt>0 pops the FIFO head. The next cycle: resp_valid_o=1, resp_id_o=popped tag, resp_data_o=dec_data_i.
REQ-027: With no accepted result, resp_valid_o=0 and resp_id_o/resp_data_o hold their values.
REQ-028: Results return in issue order; the decoder is in-order with fixed latency.
REQ-029: dec_valid_i with cnt=0 is ignored: no pop, no response, cnt unchanged. err_o is set to 1 and holds until reset.
REQ-030: busy_o = (cnt != 0), registered from cnt.
REQ-031: Throughput is one transfer per cycle sustained when cnt < MAX_OUT.

Reset
REQ-032: While rst_i=1 at a clock edge, the following clear to 0: ptr, cnt, FIFO pointers, dec_valid_o, dec_data_o, resp_valid_o, resp_id_o, resp_data_o, busy_o and err_o.
REQ-033: While rst_i=1, req_ready_o is all zero.
REQ-034: Reset mid-operation discards all in-flight tags. The decoder is reset in the same cycle by the system, so no stale results arrive afterwards.

Verification (N_REQ=4, MAX_OUT=4, decoder latency 1)
REQ-035: Single request: only req_valid_i[2] with data 6'd5.
- Response: req_ready_o=4'b0100; next cycle dec_valid_o=1, dec_data_o=5.
- Decoder returns 64'h20: the following cycle resp_valid_o=1, resp_id_o=2, resp_data_o=64'h20.
REQ-036: Fairness: all four valid continuously from reset release.
- Response: grants 0,1,2,3,0,1 on consecutive cycles; resp_id_o follows the same order.
REQ-037: Credit limit: decoder results withheld, 5 requests presented.
- Response: 4 transfers, then req_ready_o=0 with cnt=4 and busy_o=1.
- One dec_valid_i pulse: ready returns the cycle after it.
REQ-038: Simultaneous events: cnt=3, a transfer and a dec_valid_i in the same cycle.
- Response: cnt stays 3; FIFO order is preserved (the popped tag is the oldest issue).
REQ-039: Spurious result: dec_valid_i pulsed at cnt=0.
- Response: err_o=1 next cycle and held; resp_valid_o stays 0; cnt stays 0.
REQ-040: Reset mid-operation: rst_i=1 for one cycle with cnt=2.
- Response: next cycle all outputs are 0 and cnt=0.
- A new request from requester 1 is then granted normally with ptr=0.
